// File: rtl/unary_add_n_mod.sv
// -----------------------------------------------------------------------------
// unary_add_n_mod
//
// Purpose:
//   Accumulates unary pulses arriving on N_IN lanes into a modulo-(MAX+1)
//   counter. In the read phase the set bits of din are added to the counter,
//   and a one-cycle carry flag is raised whenever the sum wraps. In the write
//   phase the stored value is drained one unit per enabled cycle as a unary
//   pulse train on dout. A one-cycle drain_done pulse marks the final unit.
//
// Parameters:
//   N_IN  number of unary input lanes (1 .. MAX+1, so at most one wrap/cycle)
//   MAX   largest value the counter holds; the counter wraps modulo MAX+1
//
// Ports:
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   en            cycle enable; when low the count holds and pulses are 0
//   read_or_write 0 = read (accumulate din), 1 = write (drain to dout)
//   din           unary input lanes, each set bit adds 1 in the read phase
//   dout          registered unary output pulse (write phase)
//   carry         registered wrap flag, one cycle per wrap
//   drain_done    registered pulse on the cycle the drain reaches zero
//   count_o       current counter register
//   empty         combinational (count_o == 0)
// -----------------------------------------------------------------------------
module unary_add_n_mod #(
  parameter int N_IN = 4,
  parameter int MAX  = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          read_or_write,
  input  logic [N_IN-1:0]               din,
  output logic                          dout,
  output logic                          carry,
  output logic                          drain_done,
  output logic [$clog2(MAX+1)-1:0]      count_o,
  output logic                          empty
);

  localparam int CW = $clog2(MAX + 1);

  // Sum is kept one bit wider than the counter so the wrap test never truncates.
  localparam logic [CW:0]   MAX_W  = (CW + 1)'(MAX);
  localparam logic [CW:0]   MOD_W  = (CW + 1)'(MAX + 1);
  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  // Reject lane counts that could wrap more than once per cycle.
  if (N_IN < 1 || N_IN > MAX + 1) begin : g_bad_params
    $error("unary_add_n_mod: N_IN must lie in 1 .. MAX+1");
  end

  // Number of set lanes. N_IN <= MAX+1 <= 2**CW, so CW+1 bits always suffice.
  function automatic logic [CW:0] popcount(input logic [N_IN-1:0] v);
    logic [CW:0] acc;
    acc = {(CW + 1){1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      acc = acc + {{CW{1'b0}}, v[i]};
    end
    return acc;
  endfunction

  logic [CW-1:0] count_q, count_d;
  logic          dout_q, dout_d;
  logic          carry_q, carry_d;
  logic          drain_done_q, drain_done_d;
  logic [CW:0]   k_s;
  logic [CW:0]   sum_s;
  logic [CW:0]   wrapped_s;

  // Next-state logic for the counter and the three pulse outputs.
  always_comb begin
    k_s          = popcount(din);
    sum_s        = {1'b0, count_q} + k_s;
    wrapped_s    = sum_s - MOD_W;
    count_d      = count_q;
    dout_d       = 1'b0;
    carry_d      = 1'b0;
    drain_done_d = 1'b0;
    if (!en) begin
      count_d = count_q;
    end else if (!read_or_write) begin
      // Read phase: add lanes, wrap at most once.
      if (sum_s > MAX_W) begin
        count_d = wrapped_s[CW-1:0];
        carry_d = 1'b1;
      end else begin
        count_d = sum_s[CW-1:0];
      end
    end else if (count_q != ZERO_C) begin
      // Write phase: emit one unit and flag the last one.
      count_d      = count_q - ONE_C;
      dout_d       = 1'b1;
      drain_done_d = (count_q == ONE_C);
    end else begin
      // Write phase with nothing stored: stay at zero, no underflow.
      count_d = ZERO_C;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q      <= ZERO_C;
      dout_q       <= 1'b0;
      carry_q      <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_q       <= dout_d;
      carry_q      <= carry_d;
      drain_done_q <= drain_done_d;
    end
  end

  assign count_o    = count_q;
  assign dout       = dout_q;
  assign carry      = carry_q;
  assign drain_done = drain_done_q;
  assign empty      = (count_q == ZERO_C);

endmodule

// File: tb/tb_unary_add_n_mod.sv
// -----------------------------------------------------------------------------
// tb_unary_add_n_mod
//
// Self-checking bench for unary_add_n_mod. Two instances are exercised side by
// side: the default build (N_IN=4, MAX=10) and a small build (N_IN=4, MAX=3).
// Each cycle the bench computes the expected outputs with its own behavioural
// model, pushes them to a per-instance queue, and after the edge pops and
// compares them with the instance outputs.
// -----------------------------------------------------------------------------
module tb_unary_add_n_mod;

  typedef struct packed {
    logic [3:0] cnt;
    logic       dout;
    logic       carry;
    logic       done;
    logic       empty;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, rw_a, en_b, rw_b;
  logic [3:0] din_a, din_b;

  logic       dout_a, carry_a, done_a, empty_a;
  logic [3:0] count_a;
  logic       dout_b, carry_b, done_b, empty_b;
  logic [1:0] count_b;

  int n_checks = 0;
  int n_pass   = 0;
  int m_a      = 0;
  int m_b      = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  unary_add_n_mod #(.N_IN(4), .MAX(10)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .read_or_write(rw_a), .din(din_a),
    .dout(dout_a), .carry(carry_a), .drain_done(done_a),
    .count_o(count_a), .empty(empty_a)
  );

  unary_add_n_mod #(.N_IN(4), .MAX(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .read_or_write(rw_b), .din(din_b),
    .dout(dout_b), .carry(carry_b), .drain_done(done_b),
    .count_o(count_b), .empty(empty_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Behavioural reference: one clock edge of the counter.
  task automatic model_step(input int max, input bit rst, input bit e, input bit w,
                            input logic [3:0] d, inout int cnt, output exp_t ex);
    int k;
    int s;
    k  = $countones(d);
    ex = '0;
    if (rst) begin
      cnt = 0;
    end else if (e && !w) begin
      s = cnt + k;
      if (s > max) begin
        cnt      = s - (max + 1);
        ex.carry = 1'b1;
      end else begin
        cnt = s;
      end
    end else if (e && w && cnt > 0) begin
      ex.dout = 1'b1;
      ex.done = (cnt == 1);
      cnt     = cnt - 1;
    end
    ex.cnt   = 4'(cnt);
    ex.empty = (cnt == 0);
  endtask

  task automatic compare_one(input string tag, input exp_t ex, input logic [3:0] cnt,
                             input logic dout, input logic carry, input logic done,
                             input logic empty);
    check_eq({tag, ".count"}, {28'd0, cnt}, {28'd0, ex.cnt});
    check_eq({tag, ".dout"},  {31'd0, dout},  {31'd0, ex.dout});
    check_eq({tag, ".carry"}, {31'd0, carry}, {31'd0, ex.carry});
    check_eq({tag, ".done"},  {31'd0, done},  {31'd0, ex.done});
    check_eq({tag, ".empty"}, {31'd0, empty}, {31'd0, ex.empty});
  endtask

  // Drive one cycle on both instances, predict, then compare after the edge.
  task automatic cycle(input string tag, input bit r,
                       input bit ea, input bit wa, input logic [3:0] da,
                       input bit eb, input bit wb, input logic [3:0] db);
    exp_t ex;
    exp_t got;
    rst_n = !r;
    en_a  = ea; rw_a = wa; din_a = da;
    en_b  = eb; rw_b = wb; din_b = db;
    model_step(10, r, ea, wa, da, m_a, ex);
    q_a.push_back(ex);
    model_step(3, r, eb, wb, db, m_b, ex);
    q_b.push_back(ex);
    @(posedge clk);
    #1;
    if (q_a.size() == 0 || q_b.size() == 0) begin
      check_eq({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      got = q_a.pop_front();
      compare_one({tag, ".a"}, got, count_a, dout_a, carry_a, done_a, empty_a);
      got = q_b.pop_front();
      compare_one({tag, ".b"}, got, {2'b00, count_b}, dout_b, carry_b, done_b, empty_b);
    end
  endtask

  task automatic cyc_a(input string tag, input bit r, input bit ea, input bit wa,
                       input logic [3:0] da);
    cycle(tag, r, ea, wa, da, 1'b0, 1'b0, 4'b0000);
  endtask

  initial begin
    rst_n = 1'b0; en_a = 1'b0; rw_a = 1'b0; din_a = 4'b0000;
    en_b  = 1'b0; rw_b = 1'b0; din_b = 4'b0000;
    @(negedge clk);
    cyc_a("init_rst", 1'b1, 1'b0, 1'b0, 4'b0000);
    cyc_a("init_rst", 1'b1, 1'b1, 1'b0, 4'b1111);

    // Reset mid-drain, with en high during reset.
    cyc_a("rst_acc1", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("rst_acc2", 1'b0, 1'b1, 1'b0, 4'b0111);
    cyc_a("rst_drn",  1'b0, 1'b1, 1'b1, 4'b0000);
    cyc_a("rst_hit",  1'b1, 1'b1, 1'b1, 4'b1111);

    // Accumulate with wrap: 4, 8, 1 then carry drops.
    cyc_a("wrap1", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("wrap2", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("wrap3", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("wrap4", 1'b0, 1'b1, 1'b0, 4'b0000);

    // Boundaries: 10+1, 10+4, 9+2, 5+0.
    cyc_a("b_up1", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("b_up2", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("b_up3", 1'b0, 1'b1, 1'b0, 4'b0001);
    cyc_a("b_10p1", 1'b0, 1'b1, 1'b0, 4'b0001);
    cyc_a("b_up4", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("b_up5", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("b_up6", 1'b0, 1'b1, 1'b0, 4'b0011);
    cyc_a("b_10p4", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("b_up7", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("b_up8", 1'b0, 1'b1, 1'b0, 4'b0011);
    cyc_a("b_9p2", 1'b0, 1'b1, 1'b0, 4'b0011);
    cyc_a("b_up9", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("b_up10", 1'b0, 1'b1, 1'b0, 4'b0001);
    cyc_a("b_5p0", 1'b0, 1'b1, 1'b0, 4'b0000);

    // Drain from 3 for five cycles (count 5 -> 3 first).
    cyc_a("d_pre1", 1'b0, 1'b1, 1'b1, 4'b1111);
    cyc_a("d_pre2", 1'b0, 1'b1, 1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      cyc_a($sformatf("drain%0d", i), 1'b0, 1'b1, 1'b1, 4'b1010);
    end

    // en low mid-drain.
    cyc_a("en_acc", 1'b0, 1'b1, 1'b0, 4'b1111);
    cyc_a("en_drn", 1'b0, 1'b1, 1'b1, 4'b0000);
    cyc_a("en_off1", 1'b0, 1'b0, 1'b1, 4'b1111);
    cyc_a("en_off2", 1'b0, 1'b0, 1'b0, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      cyc_a($sformatf("en_on%0d", i), 1'b0, 1'b1, 1'b1, 4'b0000);
    end

    // Phase switch with a residual count.
    cyc_a("ph_acc", 1'b0, 1'b1, 1'b0, 4'b0011);
    cyc_a("ph_drn", 1'b0, 1'b1, 1'b1, 4'b0000);
    cyc_a("ph_add", 1'b0, 1'b1, 1'b0, 4'b0011);

    // Small build: 0+3 = 3, then 3+4 wraps back to 3 with carry.
    cycle("m3_acc",  1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0111);
    cycle("m3_wrap", 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b1111);
    cycle("m3_hold", 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000);

    // Mixed random traffic on both instances, with occasional reset.
    for (int i = 0; i < 300; i++) begin
      cycle($sformatf("rnd%0d", i), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), 4'($urandom),
            ($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unary_add_n_mod.md
Name: unary_add_n_mod

Overview:
- Parametrised successor of the 2-input unary adder. Accumulates unary pulses from N_IN input lanes into a modulo-(MAX+1) counter and flags a carry on each wrap.
- In the write phase it drains the stored value as a unary pulse train on dout.
- Sits between unary pulse sources and unary consumers in the unary arithmetic datapath. Adds lane count, modulus, a drain-complete pulse and count/empty status.

Parameters:
- N_IN, 4, number of unary input lanes. Legal range 1 to MAX+1, so at most one wrap occurs per cycle.
- MAX, 10, largest value the counter holds. The counter wraps modulo MAX+1.
- CW, $clog2(MAX+1), localparam (derived, not overridable). Counter width.

Ports:
- clk  input  1  clock; all logic updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- en  input  1  cycle enable.
- read_or_write  input  1  phase select: 0 = read (accumulate), 1 = write (drain).
- din  input  N_IN  unary input lanes; each set bit adds 1 in the read phase.
- dout  output  1  registered unary output pulse (write phase).
- carry  output  1  registered wrap flag, one cycle per wrap.
- drain_done  output  1  registered one-cycle pulse when the drain reaches zero.
- count_o  output  CW  current counter value (the register itself).
- empty  output  1  combinational, equals (count == 0).

Behaviour:
- Reset: rst_n=0 at a rising edge forces count=0, dout=0, carry=0, drain_done=0 on that edge.
  - Reset overrides en and read_or_write.
  - Reset mid-drain or mid-accumulate discards the stored value.
- en=0: count holds; dout, carry and drain_done are driven to 0 at the edge.
- Read phase (en=1, read_or_write=0):
  - k = popcount(din), computed at width CW+1.
  - s = count + k, computed at width CW+1 with no truncation.
  - If s > MAX: count <= s-(MAX+1) and carry <= 1. Otherwise count <= s and carry <= 0.
  - dout <= 0 and drain_done <= 0.
  - k=0 holds count with carry=0.
  - count=MAX with k>=1 always wraps.
- Write phase (en=1, read_or_write=1):
  - carry <= 0; din is ignored.
  - If count != 0: dout <= 1, count <= count-1, and drain_done <= 1 exactly when count == 1.
  - If count == 0: dout <= 0, drain_done <= 0, and count stays 0 (no underflow).
- Latency:
  - carry, dout and drain_done appear one cycle after the sampling edge's inputs.
  - count_o and empty reflect the register after that edge.
- Phase switch: the phase may change on any cycle. A partial drain leaves the residual count, which later reads add to.
- No internal state other than count and the three output registers.
- Legal parameter check: elaboration fails if N_IN > MAX+1 or N_IN < 1.

Test Plan:
1. Reset: accumulate count to 7, start a drain, assert rst_n=0 for one edge → count_o=0, dout=0, carry=0, drain_done=0, empty=1 after that edge; en has no effect while rst_n=0.
2. Accumulate with wrap (N_IN=4, MAX=10): din=4'b1111 on three consecutive read cycles → count_o goes 4, 8, 1; carry is 0, 0, 1; the carry on the third cycle is a single-cycle pulse.
3. Boundaries: from count=10, din=4'b0001 → count 0, carry 1. From count=10, din=4'b1111 → count 3, carry 1. From count=9, din=4'b0011 → count 0, carry 1. From count=5, din=0 → count 5, carry 0.
4. Drain: count=3, read_or_write=1 for 5 cycles → dout is 1,1,1,0,0; drain_done is 0,0,1,0,0; count_o is 2,1,0,0,0; empty=1 from the third edge on.
5. en low mid-drain: count=4, drain one cycle (count 3), then en=0 for 2 cycles → count holds at 3 and dout=0. With en=1 again → dout 1,1,1 and drain_done on the last pulse.
6. Phase switch: count=2, one write cycle (count 1, dout 1), then read with din=4'b0011 → count 3 and dout 0. Also run a MAX=3, N_IN=4 build with din=4'b1111 from count 3 → count 3, carry 1.
